// File: rtl/ysyx_24100006_wbu_pkg.sv
// Write-back stage shared definitions: GPR source and CSR op encodings, FSM states,
// trap CSR addresses and the latched instruction record. The controller uses the same codes.
package ysyx_24100006_wbu_pkg;

    typedef enum logic [2:0] {
        GPR_SRC_ALU  = 3'b000,
        GPR_SRC_LOAD = 3'b001,
        GPR_SRC_PC4  = 3'b010,
        GPR_SRC_IMM  = 3'b011,
        GPR_SRC_CSR  = 3'b100
    } gpr_src_e;

    typedef enum logic [1:0] {
        CSR_OP_WRITE  = 2'b00,
        CSR_OP_SET    = 2'b01,
        CSR_OP_CLEAR  = 2'b10,
        CSR_OP_WRITE2 = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_TRAP2 = 2'd2
    } wbu_state_e;

    localparam logic [11:0] MEPC_ADDR_DEF   = 12'h341;
    localparam logic [11:0] MCAUSE_ADDR_DEF = 12'h342;

    // Select fields stay raw bit vectors: undefined codes must fall through to zero.
    typedef struct packed {
        logic        is_break;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] sext_imm;
        logic [31:0] rs1_data;
        logic [31:0] csr_rdata;
        logic [31:0] mem_rdata;
        logic        irq;
        logic [7:0]  irq_no;
        logic        gpr_we;
        logic [3:0]  gpr_waddr;
        logic [2:0]  gpr_sel;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [1:0]  csr_op;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_24100006_MuxKey.sv
// Generic key-matched mux: each LUT entry is {key, data}, entry 0 in the low bits.
// The last matching entry wins; no match yields default_i.
module ysyx_24100006_MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                    key_i,
    input  logic [DATA_LEN-1:0]                   default_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut_i,
    output logic [DATA_LEN-1:0]                   out_o
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    always_comb begin
        out_o = default_i;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut_i[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key_i)
                out_o = lut_i[i*PAIR_LEN +: DATA_LEN];
        end
    end
endmodule

// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: latches one retired instruction, drives GPR/CSR write strobes,
// sequences trap writes (mepc then mcause) and emits one commit pulse per instruction.
module ysyx_24100006_wbu
    import ysyx_24100006_wbu_pkg::*;
#(
    parameter logic [11:0] MEPC_ADDR   = MEPC_ADDR_DEF,
    parameter logic [11:0] MCAUSE_ADDR = MCAUSE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_in_valid,
    output logic        wb_in_ready,
    input  logic        is_break_i,
    input  logic [31:0] pc_W,
    input  logic [31:0] alu_result_W,
    input  logic [31:0] sext_imm_W,
    input  logic [31:0] rs1_data_W,
    input  logic [31:0] rdata_csr_W,
    input  logic [31:0] Mem_rdata_extend,
    input  logic        irq_W,
    input  logic [7:0]  irq_no_W,
    input  logic        Gpr_Write_W,
    input  logic [3:0]  Gpr_Write_Addr_W,
    input  logic [2:0]  Gpr_Write_RD_W,
    input  logic        Csr_Write_W,
    input  logic [11:0] Csr_Write_Addr_W,
    input  logic [1:0]  Csr_Write_RD_W,
    output logic        gpr_wen,
    output logic [3:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        ebreak_o
);
    wbu_state_e state_q, state_d;
    wb_entry_t  entry_q, entry_d;
    wb_entry_t  entry_in;
    logic [31:0] pc_plus4;
    logic [31:0] csr_op_data;

    assign entry_in = '{
        is_break:   is_break_i,
        pc:         pc_W,
        alu_result: alu_result_W,
        sext_imm:   sext_imm_W,
        rs1_data:   rs1_data_W,
        csr_rdata:  rdata_csr_W,
        mem_rdata:  Mem_rdata_extend,
        irq:        irq_W,
        irq_no:     irq_no_W,
        gpr_we:     Gpr_Write_W,
        gpr_waddr:  Gpr_Write_Addr_W,
        gpr_sel:    Gpr_Write_RD_W,
        csr_we:     Csr_Write_W,
        csr_waddr:  Csr_Write_Addr_W,
        csr_op:     Csr_Write_RD_W
    };

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = entry_q.pc + 32'd4;

    ysyx_24100006_MuxKey #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u_gpr_mux (
        .key_i     (entry_q.gpr_sel),
        .default_i (32'd0),
        .lut_i     ({GPR_SRC_CSR,  entry_q.csr_rdata,
                     GPR_SRC_IMM,  entry_q.sext_imm,
                     GPR_SRC_PC4,  pc_plus4,
                     GPR_SRC_LOAD, entry_q.mem_rdata,
                     GPR_SRC_ALU,  entry_q.alu_result}),
        .out_o     (gpr_wdata)
    );

    ysyx_24100006_MuxKey #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32)) u_csr_mux (
        .key_i     (entry_q.csr_op),
        .default_i (entry_q.rs1_data),
        .lut_i     ({CSR_OP_WRITE2, entry_q.rs1_data,
                     CSR_OP_CLEAR,  entry_q.csr_rdata & ~entry_q.rs1_data,
                     CSR_OP_SET,    entry_q.csr_rdata | entry_q.rs1_data,
                     CSR_OP_WRITE,  entry_q.rs1_data}),
        .out_o     (csr_op_data)
    );

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        wb_in_ready  = 1'b0;
        gpr_wen      = 1'b0;
        csr_wen      = 1'b0;
        csr_waddr    = entry_q.csr_waddr;
        csr_wdata    = csr_op_data;
        commit_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                wb_in_ready = 1'b1;
                if (wb_in_valid) begin
                    entry_d = entry_in;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                gpr_wen = entry_q.gpr_we && (entry_q.gpr_waddr != 4'd0);
                // A trap overrides the instruction's own CSR write.
                if (entry_q.irq) begin
                    csr_wen   = 1'b1;
                    csr_waddr = MEPC_ADDR;
                    csr_wdata = entry_q.pc;
                    state_d   = S_TRAP2;
                end else begin
                    csr_wen      = entry_q.csr_we;
                    commit_valid = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_TRAP2: begin
                csr_wen      = 1'b1;
                csr_waddr    = MCAUSE_ADDR;
                csr_wdata    = {24'd0, entry_q.irq_no};
                commit_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gpr_waddr = entry_q.gpr_waddr;
    assign commit_pc = entry_q.pc;
    assign ebreak_o  = entry_q.is_break && commit_valid;

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Randomized and directed bench for the write-back stage, checked against an
// instruction-level model of what each retired instruction must write.
module tb_ysyx_24100006_wbu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_in_valid = 1'b0;
    logic        wb_in_ready;
    logic        is_break_i = 1'b0;
    logic [31:0] pc_W = '0, alu_result_W = '0, sext_imm_W = '0, rs1_data_W = '0;
    logic [31:0] rdata_csr_W = '0, Mem_rdata_extend = '0;
    logic        irq_W = 1'b0;
    logic [7:0]  irq_no_W = '0;
    logic        Gpr_Write_W = 1'b0;
    logic [3:0]  Gpr_Write_Addr_W = '0;
    logic [2:0]  Gpr_Write_RD_W = '0;
    logic        Csr_Write_W = 1'b0;
    logic [11:0] Csr_Write_Addr_W = '0;
    logic [1:0]  Csr_Write_RD_W = '0;
    logic        gpr_wen, csr_wen, commit_valid, ebreak_o;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata, csr_wdata, commit_pc;
    logic [11:0] csr_waddr;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        brk;
        logic [31:0] pc, alu, imm, rs1, csr, mem;
        logic        irq;
        logic [7:0]  no;
        logic        gw;
        logic [3:0]  rd;
        logic [2:0]  sel;
        logic        cw;
        logic [11:0] ca;
        logic [1:0]  op;
    } txn_t;

    ysyx_24100006_wbu dut (
        .clk(clk), .reset(reset), .wb_in_valid(wb_in_valid), .wb_in_ready(wb_in_ready),
        .is_break_i(is_break_i), .pc_W(pc_W), .alu_result_W(alu_result_W),
        .sext_imm_W(sext_imm_W), .rs1_data_W(rs1_data_W), .rdata_csr_W(rdata_csr_W),
        .Mem_rdata_extend(Mem_rdata_extend), .irq_W(irq_W), .irq_no_W(irq_no_W),
        .Gpr_Write_W(Gpr_Write_W), .Gpr_Write_Addr_W(Gpr_Write_Addr_W),
        .Gpr_Write_RD_W(Gpr_Write_RD_W), .Csr_Write_W(Csr_Write_W),
        .Csr_Write_Addr_W(Csr_Write_Addr_W), .Csr_Write_RD_W(Csr_Write_RD_W),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .ebreak_o(ebreak_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gpr(input txn_t t);
        case (t.sel)
            3'd0:    return t.alu;
            3'd1:    return t.mem;
            3'd2:    return t.pc + 32'd4;
            3'd3:    return t.imm;
            3'd4:    return t.csr;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_csr(input txn_t t);
        if (t.op == 2'd1) return t.csr | t.rs1;
        if (t.op == 2'd2) return t.csr & ~t.rs1;
        return t.rs1;
    endfunction

    function automatic txn_t zero_txn();
        txn_t t;
        t = '{brk:0, pc:0, alu:0, imm:0, rs1:0, csr:0, mem:0, irq:0, no:0,
              gw:0, rd:0, sel:0, cw:0, ca:0, op:0};
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.brk = ($urandom_range(0, 7) == 0);
        t.pc  = $urandom; t.alu = $urandom; t.imm = $urandom;
        t.rs1 = $urandom; t.csr = $urandom; t.mem = $urandom;
        t.irq = ($urandom_range(0, 3) == 0);
        t.no  = 8'($urandom);
        t.gw  = 1'($urandom); t.rd = 4'($urandom); t.sel = 3'($urandom_range(0, 7));
        t.cw  = 1'($urandom); t.ca = 12'($urandom); t.op = 2'($urandom);
        return t;
    endfunction

    task automatic apply(input txn_t t);
        is_break_i = t.brk; pc_W = t.pc; alu_result_W = t.alu; sext_imm_W = t.imm;
        rs1_data_W = t.rs1; rdata_csr_W = t.csr; Mem_rdata_extend = t.mem;
        irq_W = t.irq; irq_no_W = t.no; Gpr_Write_W = t.gw; Gpr_Write_Addr_W = t.rd;
        Gpr_Write_RD_W = t.sel; Csr_Write_W = t.cw; Csr_Write_Addr_W = t.ca;
        Csr_Write_RD_W = t.op;
    endtask

    // Entered and left at a negedge with the DUT idle. Upstream keeps toggling
    // valid with junk data while the stage is busy; it must be ignored.
    task automatic exec(input txn_t t, input string tag);
        logic [31:0] eg;
        eg = ref_gpr(t);
        apply(t);
        wb_in_valid = 1'b1;
        vectors++;
        if (wb_in_ready !== 1'b1) begin
            miscompares++; $display("FAIL %s idle_ready got=%b want=1", tag, wb_in_ready);
        end
        @(posedge clk); #1;
        apply(rand_txn());
        wb_in_valid = 1'($urandom);
        @(negedge clk);
        vectors += 10;
        if (wb_in_ready !== 1'b0) begin
            miscompares++; $display("FAIL %s wb_ready got=%b want=0", tag, wb_in_ready);
        end
        if (gpr_wen !== (t.gw && t.rd != 0)) begin
            miscompares++; $display("FAIL %s gpr_wen got=%b want=%b", tag, gpr_wen, t.gw && t.rd != 0);
        end
        if (gpr_waddr !== t.rd) begin
            miscompares++; $display("FAIL %s gpr_waddr got=%0d want=%0d", tag, gpr_waddr, t.rd);
        end
        if (gpr_wdata !== eg) begin
            miscompares++; $display("FAIL %s gpr_wdata got=%h want=%h", tag, gpr_wdata, eg);
        end
        if (csr_wen !== (t.irq ? 1'b1 : t.cw)) begin
            miscompares++; $display("FAIL %s wb_csr_wen got=%b want=%b", tag, csr_wen, t.irq ? 1'b1 : t.cw);
        end
        if (csr_waddr !== (t.irq ? 12'h341 : t.ca)) begin
            miscompares++; $display("FAIL %s wb_csr_waddr got=%h want=%h", tag, csr_waddr, t.irq ? 12'h341 : t.ca);
        end
        if (csr_wdata !== (t.irq ? t.pc : ref_csr(t))) begin
            miscompares++; $display("FAIL %s wb_csr_wdata got=%h want=%h", tag, csr_wdata, t.irq ? t.pc : ref_csr(t));
        end
        if (commit_valid !== !t.irq) begin
            miscompares++; $display("FAIL %s wb_commit got=%b want=%b", tag, commit_valid, !t.irq);
        end
        if (ebreak_o !== (t.brk && !t.irq)) begin
            miscompares++; $display("FAIL %s wb_ebreak got=%b want=%b", tag, ebreak_o, t.brk && !t.irq);
        end
        if (commit_pc !== t.pc) begin
            miscompares++; $display("FAIL %s commit_pc got=%h want=%h", tag, commit_pc, t.pc);
        end
        if (t.irq) begin
            @(negedge clk);
            vectors += 6;
            if (csr_wen !== 1'b1) begin
                miscompares++; $display("FAIL %s trap_csr_wen got=%b want=1", tag, csr_wen);
            end
            if (csr_waddr !== 12'h342) begin
                miscompares++; $display("FAIL %s trap_csr_waddr got=%h want=342", tag, csr_waddr);
            end
            if (csr_wdata !== {24'd0, t.no}) begin
                miscompares++; $display("FAIL %s trap_csr_wdata got=%h want=%h", tag, csr_wdata, {24'd0, t.no});
            end
            if (commit_valid !== 1'b1) begin
                miscompares++; $display("FAIL %s trap_commit got=%b want=1", tag, commit_valid);
            end
            if (ebreak_o !== t.brk) begin
                miscompares++; $display("FAIL %s trap_ebreak got=%b want=%b", tag, ebreak_o, t.brk);
            end
            if ({gpr_wen, wb_in_ready} !== 2'b00) begin
                miscompares++; $display("FAIL %s trap_gpr_ready got=%b want=00", tag, {gpr_wen, wb_in_ready});
            end
        end
        @(negedge clk);
        vectors += 2;
        if ({wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o} !== 5'b10000) begin
            miscompares++; $display("FAIL %s after_idle got=%b want=10000", tag,
                                    {wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o});
        end
        if (gpr_wdata !== eg) begin
            miscompares++; $display("FAIL %s hold_gpr_wdata got=%h want=%h", tag, gpr_wdata, eg);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors += 3;
        if ({wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o} !== 5'b10000) begin
            miscompares++; $display("FAIL reset_strobes got=%b want=10000",
                                    {wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o});
        end
        if ({gpr_waddr, csr_waddr} !== 16'd0 || commit_pc !== 32'd0) begin
            miscompares++; $display("FAIL reset_addr got=%h/%h/%h want=0", gpr_waddr, csr_waddr, commit_pc);
        end
        if (gpr_wdata !== 32'd0 || csr_wdata !== 32'd0) begin
            miscompares++; $display("FAIL reset_data got=%h/%h want=0", gpr_wdata, csr_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        txn_t t;
        t = zero_txn(); t.alu = 32'h5; t.rd = 4'd3; t.gw = 1'b1; t.sel = 3'd0;
        exec(t, "addi");
        t = zero_txn(); t.mem = 32'hFFFF_FF80; t.rd = 4'd0; t.gw = 1'b1; t.sel = 3'd1;
        exec(t, "load_x0");
        t = zero_txn(); t.pc = 32'h8000_0010; t.rd = 4'd1; t.gw = 1'b1; t.sel = 3'd2;
        exec(t, "jal");
        t.pc = 32'hFFFF_FFFC;
        exec(t, "jal_wrap");
        t = zero_txn(); t.rs1 = 32'h0F; t.csr = 32'hF0; t.op = 2'd1; t.ca = 12'h300;
        t.cw = 1'b1; t.gw = 1'b1; t.rd = 4'd5; t.sel = 3'd4;
        exec(t, "csrrs");
        t.op = 2'd2; t.rs1 = 32'h30;
        exec(t, "csrrc");
        t = zero_txn(); t.irq = 1'b1; t.no = 8'd11; t.pc = 32'h8000_0100;
        t.cw = 1'b1; t.ca = 12'h300; t.rs1 = 32'h1234;
        exec(t, "ecall");
        t = zero_txn(); t.brk = 1'b1; t.pc = 32'h8000_0200;
        exec(t, "ebreak");
    endtask

    task automatic test_reset_in_trap();
        txn_t t;
        t = zero_txn(); t.irq = 1'b1; t.no = 8'd7; t.pc = 32'h8000_0300;
        apply(t);
        wb_in_valid = 1'b1;
        @(posedge clk); #1;
        wb_in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (csr_waddr !== 12'h341 || csr_wen !== 1'b1) begin
            miscompares++; $display("FAIL rst_trap_mepc got=%b/%h want=1/341", csr_wen, csr_waddr);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vectors += 2;
        if ({wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o} !== 5'b10000) begin
            miscompares++; $display("FAIL rst_trap_strobes got=%b want=10000",
                                    {wb_in_ready, gpr_wen, csr_wen, commit_valid, ebreak_o});
        end
        if (csr_waddr !== 12'd0 || commit_pc !== 32'd0) begin
            miscompares++; $display("FAIL rst_trap_cleared got=%h/%h want=0", csr_waddr, commit_pc);
        end
        reset = 1'b0;
        t = zero_txn(); t.brk = 1'b1; t.pc = 32'h8000_0400; t.gw = 1'b1; t.rd = 4'd2;
        exec(t, "ebreak_after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) exec(rand_txn(), $sformatf("rand%0d", i));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_trap();
        test_back_to_back();
        wb_in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
